// File: rtl/apb4_mon_pkg.sv
// Shared types and constants for the APB4 protocol monitor.
package apb4_mon_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int VIOL_W       = 9;
    localparam int V_SEL_ONEHOT = 0;
    localparam int V_DECODE     = 1;
    localparam int V_NO_SETUP   = 2;
    localparam int V_NO_ACCESS  = 3;
    localparam int V_UNSTABLE   = 4;
    localparam int V_EN_HOLD    = 5;
    localparam int V_TIMEOUT    = 6;
    localparam int V_RD_STRB    = 7;
    localparam int V_EN_NO_SEL  = 8;

    // Index of the lowest set violation bit (0 when none are set).
    function automatic logic [3:0] first_index(input logic [VIOL_W-1:0] v);
        first_index = 4'd0;
        for (int i = VIOL_W - 1; i >= 0; i--) begin
            if (v[i]) first_index = 4'(i);
        end
    endfunction

endpackage

// File: rtl/apb4_sat_counter.sv
// Saturating event counter with synchronous clear; a clear coinciding with
// an increment leaves the counter at 1.
module apb4_sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] cnt
);

    // Clear first, then count; hold at all-ones.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CNT_WIDTH'(inc);
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/apb4_protocol_monitor.sv
// Passive APB4 bus monitor: phase tracking, protocol checks, timeout,
// sticky violation flags and transfer statistics.
//
// state  | meaning
// IDLE   | no transfer in flight; current cycle may start a setup phase
// SETUP  | setup seen last cycle; current cycle must be the first access cycle
// ACCESS | in access phase (done_q=0) or one cycle after completion (done_q=1)
//
// The first access cycle is evaluated while still in SETUP, so zero-wait
// transfers complete there and every PREADY-low access cycle counts as a wait.
module apb4_protocol_monitor
    import apb4_mon_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [NUM_SLAVES-1:0]   PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic                    clr_i,
    output logic [VIOL_W-1:0]       viol_o,
    output logic                    viol_pulse_o,
    output logic [3:0]              first_viol_o,
    output logic                    first_viol_vld_o,
    output logic [CNT_WIDTH-1:0]    wr_cnt_o,
    output logic [CNT_WIDTH-1:0]    rd_cnt_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o,
    output logic                    busy_o
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SEL_W      = $clog2(NUM_SLAVES);
    localparam int WAIT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT_CYCLES);

    apb_state_t              state_q, state_d;
    logic                    done_q, done_d;
    logic [NUM_SLAVES-1:0]   cap_sel;
    logic [ADDR_WIDTH-1:0]   cap_addr;
    logic                    cap_write;
    logic [DATA_WIDTH-1:0]   cap_wdata;
    logic [STRB_WIDTH-1:0]   cap_strb;
    logic [2:0]              cap_prot;
    logic [WAIT_W-1:0]       wait_q, wait_d, wait_base;
    logic                    capture, start_cyc, post_cyc, access_cyc;
    logic                    inc_wr, inc_rd, inc_err;
    logic [VIOL_W-1:0]       viol_now, viol_base;
    logic                    fvld_base;
    logic                    sel_any, sel_multi;
    logic [SEL_W-1:0]        sel_idx;

    assign sel_any   = |PSEL;
    assign sel_multi = |(PSEL & (PSEL - NUM_SLAVES'(1)));
    assign busy_o    = (state_q != IDLE);

    // Encode the selected slave index (meaningful only when PSEL is one-hot).
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (PSEL[i]) sel_idx = SEL_W'(i);
        end
    end

    // Phase tracking, per-cycle checks and completion detection.
    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        capture    = 1'b0;
        wait_d     = wait_q;
        wait_base  = wait_q;
        start_cyc  = 1'b0;
        post_cyc   = 1'b0;
        access_cyc = 1'b0;
        inc_wr     = 1'b0;
        inc_rd     = 1'b0;
        inc_err    = 1'b0;
        viol_now   = '0;
        viol_now[V_SEL_ONEHOT] = sel_multi;
        viol_now[V_EN_NO_SEL]  = PENABLE && !sel_any;
        viol_now[V_DECODE]     = sel_any && !sel_multi &&
                                 (sel_idx != PADDR[ADDR_WIDTH-1 -: SEL_W]);

        case (state_q)
            IDLE: start_cyc = 1'b1;
            SETUP: begin
                if (PENABLE && (PSEL == cap_sel)) begin
                    access_cyc = 1'b1;
                    wait_base  = '0;
                    wait_d     = '0;
                    state_d    = ACCESS;
                end else begin
                    viol_now[V_NO_ACCESS] = 1'b1;
                    start_cyc = 1'b1;
                end
            end
            ACCESS: begin
                if (done_q) begin
                    post_cyc  = 1'b1;
                    start_cyc = 1'b1;
                end else begin
                    access_cyc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_cyc) begin
            state_d = IDLE;
            if (sel_any && !PENABLE) begin
                state_d = SETUP;
                capture = 1'b1;
            end else if (PENABLE && post_cyc) begin
                viol_now[V_EN_HOLD] = 1'b1;
            end else if (PENABLE && sel_any) begin
                viol_now[V_NO_SETUP] = 1'b1;
            end
        end

        if (access_cyc) begin
            state_d = ACCESS;
            if (PREADY) begin
                done_d  = 1'b1;
                inc_wr  = cap_write;
                inc_rd  = !cap_write;
                inc_err = PSLVERR;
                viol_now[V_RD_STRB] = !cap_write && (|cap_strb);
            end else begin
                viol_now[V_UNSTABLE] = !PENABLE || (PSEL != cap_sel) ||
                                       (PADDR != cap_addr) || (PWRITE != cap_write) ||
                                       (PSTRB != cap_strb) || (PPROT != cap_prot) ||
                                       (cap_write && (PWDATA != cap_wdata));
                viol_now[V_TIMEOUT]  = (wait_base == WAIT_MAX - WAIT_W'(1));
                wait_d = (wait_base == WAIT_MAX) ? WAIT_MAX : wait_base + WAIT_W'(1);
            end
        end
    end

    // FSM state, wait counter and captured setup-phase fields.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            wait_q    <= '0;
            cap_sel   <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            cap_prot  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            wait_q  <= wait_d;
            if (capture) begin
                cap_sel   <= PSEL;
                cap_addr  <= PADDR;
                cap_write <= PWRITE;
                cap_wdata <= PWDATA;
                cap_strb  <= PSTRB;
                cap_prot  <= PPROT;
            end
        end
    end

    assign viol_base = clr_i ? '0 : viol_o;
    assign fvld_base = clr_i ? 1'b0 : first_viol_vld_o;

    // Sticky flags and first-violation latch; a clear is applied before new events.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            viol_o           <= '0;
            viol_pulse_o     <= 1'b0;
            first_viol_o     <= '0;
            first_viol_vld_o <= 1'b0;
        end else begin
            viol_o       <= viol_base | viol_now;
            viol_pulse_o <= |(viol_now & ~viol_base);
            if (!fvld_base && (|viol_now)) begin
                first_viol_o     <= first_index(viol_now);
                first_viol_vld_o <= 1'b1;
            end else if (clr_i) begin
                first_viol_o     <= '0;
                first_viol_vld_o <= 1'b0;
            end
        end
    end

    apb4_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_wr_cnt (
        .PCLK(PCLK), .PRESETn(PRESETn), .inc(inc_wr), .clr(clr_i), .cnt(wr_cnt_o)
    );
    apb4_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rd_cnt (
        .PCLK(PCLK), .PRESETn(PRESETn), .inc(inc_rd), .clr(clr_i), .cnt(rd_cnt_o)
    );
    apb4_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .PCLK(PCLK), .PRESETn(PRESETn), .inc(inc_err), .clr(clr_i), .cnt(err_cnt_o)
    );

endmodule

// File: tb/tb_apb4_protocol_monitor.sv
// Directed bench for apb4_protocol_monitor: vector table plus hand sequences.
module tb_apb4_protocol_monitor;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic [3:0]  PSEL;
    logic        PENABLE, PWRITE, PREADY, PSLVERR, clr_i;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [8:0]  viol_o;
    logic        viol_pulse_o, first_viol_vld_o, busy_o;
    logic [3:0]  first_viol_o, wr_cnt_o, rd_cnt_o, err_cnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    apb4_protocol_monitor #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_SLAVES(4),
        .TIMEOUT_CYCLES(16), .CNT_WIDTH(4)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PREADY(PREADY), .PSLVERR(PSLVERR), .clr_i(clr_i),
        .viol_o(viol_o), .viol_pulse_o(viol_pulse_o), .first_viol_o(first_viol_o),
        .first_viol_vld_o(first_viol_vld_o), .wr_cnt_o(wr_cnt_o),
        .rd_cnt_o(rd_cnt_o), .err_cnt_o(err_cnt_o), .busy_o(busy_o)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        logic [3:0]  sel;
        logic        en, wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        rdy, err, clr;
        logic [8:0]  e_viol;
        logic        e_pulse;
        logic [3:0]  e_first;
        logic        e_fvld;
        logic [3:0]  e_wr, e_rd, e_err;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [3:0] sel, logic en, logic wr, logic [31:0] addr,
                                logic [3:0] strb, logic rdy, logic err, logic clr,
                                logic [8:0] e_viol, logic e_pulse, logic [3:0] e_first,
                                logic e_fvld, logic [3:0] e_wr, logic [3:0] e_rd,
                                logic [3:0] e_err, logic e_busy);
        vec_t v;
        v.sel = sel; v.en = en; v.wr = wr; v.addr = addr; v.strb = strb;
        v.rdy = rdy; v.err = err; v.clr = clr; v.e_viol = e_viol; v.e_pulse = e_pulse;
        v.e_first = e_first; v.e_fvld = e_fvld; v.e_wr = e_wr; v.e_rd = e_rd;
        v.e_err = e_err; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive after the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic [3:0] sel, input logic en, input logic wr,
                       input logic [31:0] addr, input logic [3:0] strb,
                       input logic rdy, input logic err, input logic clr);
        @(negedge PCLK);
        PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PSTRB = strb;
        PREADY = rdy; PSLVERR = err; clr_i = clr;
        @(posedge PCLK);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " viol"}, 32'(viol_o), 0);
        chk({tag, " pulse"}, 32'(viol_pulse_o), 0);
        chk({tag, " first"}, 32'(first_viol_o), 0);
        chk({tag, " fvld"}, 32'(first_viol_vld_o), 0);
        chk({tag, " wr"}, 32'(wr_cnt_o), 0);
        chk({tag, " rd"}, 32'(rd_cnt_o), 0);
        chk({tag, " err"}, 32'(err_cnt_o), 0);
        chk({tag, " busy"}, 32'(busy_o), 0);
    endtask

    initial begin
        PRESETn = 1'b0; PSEL = '0; PENABLE = 0; PWRITE = 0; PADDR = '0;
        PWDATA = 32'h1234_5678; PSTRB = '0; PPROT = 3'b010; PREADY = 0;
        PSLVERR = 0; clr_i = 0;

        //            sel   en wr addr           strb rdy err clr  viol    pu fst fv wr rd er bsy
        // single write, one wait state
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(4'h2, 0, 1, 32'h4000_0010, 4'hF, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'h2, 1, 1, 32'h4000_0010, 4'hF, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'h2, 1, 1, 32'h4000_0010, 4'hF, 1, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 9'h000, 0, 0, 0, 1, 0, 0, 0));
        // mis-decoded read, zero wait
        vecs.push_back(mk(4'h4, 0, 0, 32'hC000_0000, 4'h0, 0, 0, 0, 9'h002, 1, 1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(4'h4, 1, 0, 32'hC000_0000, 4'h0, 1, 0, 0, 9'h002, 0, 1, 1, 1, 1, 0, 1));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 9'h002, 0, 1, 1, 1, 1, 0, 0));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 1, 9'h000, 0, 0, 0, 0, 0, 0, 0));
        // address changes during wait; PSLVERR during a wait is ignored
        vecs.push_back(mk(4'h1, 0, 1, 32'h0000_0100, 4'hF, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'h1, 1, 1, 32'h0000_0100, 4'hF, 0, 1, 0, 9'h000, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'h1, 1, 1, 32'h0000_0104, 4'hF, 0, 0, 0, 9'h010, 1, 4, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4'h1, 1, 1, 32'h0000_0104, 4'hF, 1, 0, 0, 9'h010, 0, 4, 1, 1, 0, 0, 1));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 9'h010, 0, 4, 1, 1, 0, 0, 0));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 1, 9'h000, 0, 0, 0, 0, 0, 0, 0));
        // enable without setup, then setup not followed by access
        vecs.push_back(mk(4'h1, 1, 0, 32'h0,         4'h0, 0, 0, 0, 9'h004, 1, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 9'h004, 0, 2, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4'h1, 0, 0, 32'h0,         4'h0, 0, 0, 0, 9'h004, 0, 2, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 9'h00C, 1, 2, 1, 0, 0, 0, 0));
        // clear coinciding with a multi-select violation
        vecs.push_back(mk(4'h3, 0, 0, 32'h0,         4'h0, 0, 0, 1, 9'h001, 1, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 0, 9'h009, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 1, 9'h000, 0, 0, 0, 0, 0, 0, 0));
        // read with strobes, then PENABLE held with PSEL dropped
        vecs.push_back(mk(4'h1, 0, 0, 32'h0,         4'h1, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(4'h1, 1, 0, 32'h0,         4'h1, 1, 0, 0, 9'h080, 1, 7, 1, 0, 1, 0, 1));
        vecs.push_back(mk(4'h0, 1, 0, 32'h0,         4'h0, 0, 0, 0, 9'h1A0, 1, 7, 1, 0, 1, 0, 0));
        vecs.push_back(mk(4'h0, 0, 0, 32'h0,         4'h0, 0, 0, 1, 9'h000, 0, 0, 0, 0, 0, 0, 0));

        repeat (3) @(negedge PCLK);
        #1;
        chk_all_zero("reset");
        @(negedge PCLK);
        PRESETn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].sel, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].strb,
                vecs[i].rdy, vecs[i].err, vecs[i].clr);
            chk($sformatf("v%0d viol", i),  32'(viol_o),           32'(vecs[i].e_viol));
            chk($sformatf("v%0d pulse", i), 32'(viol_pulse_o),     32'(vecs[i].e_pulse));
            chk($sformatf("v%0d first", i), 32'(first_viol_o),     32'(vecs[i].e_first));
            chk($sformatf("v%0d fvld", i),  32'(first_viol_vld_o), 32'(vecs[i].e_fvld));
            chk($sformatf("v%0d wr", i),    32'(wr_cnt_o),         32'(vecs[i].e_wr));
            chk($sformatf("v%0d rd", i),    32'(rd_cnt_o),         32'(vecs[i].e_rd));
            chk($sformatf("v%0d err", i),   32'(err_cnt_o),        32'(vecs[i].e_err));
            chk($sformatf("v%0d busy", i),  32'(busy_o),           32'(vecs[i].e_busy));
        end

        // Timeout: 20 wait cycles, flag appears after the 16th, single pulse.
        cyc(4'h1, 0, 0, 32'h0, 4'h0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            cyc(4'h1, 1, 0, 32'h0, 4'h0, 0, 0, 0);
            chk($sformatf("to%0d flag", k),  32'(viol_o[6]),     32'(k >= 16));
            chk($sformatf("to%0d pulse", k), 32'(viol_pulse_o), 32'(k == 16));
        end
        cyc(4'h1, 1, 0, 32'h0, 4'h0, 1, 0, 0);
        cyc(4'h0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
        chk("to viol", 32'(viol_o), 32'h040);
        chk("to first", 32'(first_viol_o), 6);
        chk("to rd", 32'(rd_cnt_o), 1);
        cyc(4'h0, 0, 0, 32'h0, 4'h0, 0, 0, 1);

        // Three back-to-back zero-wait reads, the second erroring.
        for (int t = 0; t < 3; t++) begin
            cyc(4'h1, 0, 0, 32'h0, 4'h0, 0, 0, 0);
            cyc(4'h1, 1, 0, 32'h0, 4'h0, 1, (t == 1), 0);
            chk($sformatf("b2b%0d busy", t), 32'(busy_o), 1);
        end
        cyc(4'h0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
        chk("b2b rd", 32'(rd_cnt_o), 3);
        chk("b2b err", 32'(err_cnt_o), 1);
        chk("b2b viol", 32'(viol_o), 0);
        chk("b2b busy end", 32'(busy_o), 0);

        // Clear in the completion cycle: counter restarts at 1.
        cyc(4'h1, 0, 0, 32'h0, 4'h0, 0, 0, 0);
        cyc(4'h1, 1, 0, 32'h0, 4'h0, 1, 0, 1);
        chk("clrc rd", 32'(rd_cnt_o), 1);
        chk("clrc err", 32'(err_cnt_o), 0);
        cyc(4'h0, 0, 0, 32'h0, 4'h0, 0, 0, 1);

        // 17 writes into a 4-bit counter.
        for (int w = 1; w <= 17; w++) begin
            cyc(4'h1, 0, 1, 32'h0, 4'hF, 0, 0, 0);
            cyc(4'h1, 1, 1, 32'h0, 4'hF, 1, 0, 0);
            chk($sformatf("sat%0d wr", w), 32'(wr_cnt_o), (w > 15) ? 15 : w);
        end

        // Reset asserted in the middle of an access with PREADY low.
        cyc(4'h1, 0, 0, 32'h0, 4'h1, 0, 0, 0);
        cyc(4'h1, 1, 0, 32'h0, 4'h1, 0, 0, 0);
        chk("mid busy", 32'(busy_o), 1);
        #2;
        PRESETn = 1'b0;
        #1;
        chk_all_zero("midrst");
        @(negedge PCLK);
        PSEL = '0; PENABLE = 0; PREADY = 0;
        PRESETn = 1'b1;
        cyc(4'h0, 0, 0, 32'h0, 4'h0, 0, 0, 0);
        chk_all_zero("postrst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
